// File: rtl/spi_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_ctrl_pkg
//   Shared definitions for the SPI transfer sequencer:
//     - state_t          : sequencer FSM states
//     - DEF_DATA_W       : default SPI word width
//     - DEF_XFER_CYCLES  : default mclk cycles from start pulse to shift-complete
//     - idx_width()      : width of an index into n requesters (at least 1 bit)
// ---------------------------------------------------------------------------
package spi_ctrl_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_XFER_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_READ,
        ST_CAPT
    } state_t;

    // A single requester still needs a 1-bit index so ports never collapse
    // to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spi_rr_arbiter
//   Combinational round-robin arbiter. Starting one position after ptr and
//   wrapping around, the first requester with req set wins.
//   Ports:
//     req    in  NREQ   pending requests
//     ptr    in  IDX_W  last requester served (search starts at ptr+1)
//     grant  out NREQ   one-hot grant (all zero when no request)
//     idx    out IDX_W  index of the granted requester
//     found  out 1      some requester was granted
// ---------------------------------------------------------------------------
module spi_rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Candidate position for search step off (1..NREQ) relative to base.
    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NREQ;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path
        // through the block leaves a value unassigned, which would infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // Offset NREQ lands back on ptr itself, so the last-served requester
        // is only picked when nobody else is asking. With NREQ=1 this reduces
        // to a fixed grant of requester 0.
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[wrap_idx(int'(ptr), k)]) begin
                found                        = 1'b1;
                grant[wrap_idx(int'(ptr), k)] = 1'b1;
                idx                          = IDX_W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// spi_xfer_sequencer
//   Runs complete SPI exchanges on a master/slave shift-register core on
//   behalf of NREQ requesters, one transaction at a time:
//     IDLE -> LOAD -> START -> WAIT (XFER_CYCLES) -> READ -> CAPT -> IDLE
//   Requesters are served round-robin; the response pulses on rsp_valid of
//   the owning requester in the cycle after CAPT.
//   Ports:
//     mclk, reset                    clock, async active-low reset
//     req_valid/req_ready            per-requester handshake (ready one-hot, IDLE only)
//     req_mdata/req_sdata            packed words, slice i = [i*DATA_W +: DATA_W]
//     rsp_valid                      one-cycle pulse to the owner, no backpressure
//     rsp_mdata/rsp_sdata            core results captured for the last transaction
//     busy                           high whenever the FSM is not in IDLE
//     load_*/start/read_*            one-cycle control pulses to the core
//     data_in_master/data_in_slave   latched words presented to the core
//     data_out_master/data_out_slave results returned by the core
// ---------------------------------------------------------------------------
module spi_xfer_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int XFER_CYCLES = DEF_XFER_CYCLES
) (
    input  logic                   mclk,
    input  logic                   reset,

    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_mdata,
    input  logic [NREQ*DATA_W-1:0] req_sdata,

    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_mdata,
    output logic [DATA_W-1:0]      rsp_sdata,

    output logic                   busy,

    output logic                   load_master,
    output logic                   load_slave,
    output logic                   start,
    output logic                   read_master,
    output logic                   read_slave,
    output logic [DATA_W-1:0]      data_in_master,
    output logic [DATA_W-1:0]      data_in_slave,
    input  logic [DATA_W-1:0]      data_out_master,
    input  logic [DATA_W-1:0]      data_out_slave
);

    localparam int IDX_W = idx_width(NREQ);
    // Sized to hold XFER_CYCLES so the WAIT increment can never wrap.
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [NREQ-1:0]  owner_grant;
    logic [CNT_W-1:0] count;

    // Master and slave always load/read together, so one register drives both.
    logic             load_q;
    logic             read_q;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;

    spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_found)
    );

    // Ready is offered only while IDLE; elsewhere requesters simply hold.
    assign req_ready   = (state == ST_IDLE) ? grant : '0;

    assign load_master = load_q;
    assign load_slave  = load_q;
    assign read_master = read_q;
    assign read_slave  = read_q;

    // Control pulses are set on the transition into the state they belong
    // to, so each is a flop output that is high for exactly that state.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            rr_ptr         <= IDX_W'(NREQ - 1);
            owner_grant    <= '0;
            count          <= '0;
            load_q         <= 1'b0;
            start          <= 1'b0;
            read_q         <= 1'b0;
            busy           <= 1'b0;
            rsp_valid      <= '0;
            rsp_mdata      <= '0;
            rsp_sdata      <= '0;
            data_in_master <= '0;
            data_in_slave  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values and the default clears below are
            // cleanly overridden by the later case branch.
            load_q    <= 1'b0;
            start     <= 1'b0;
            read_q    <= 1'b0;
            rsp_valid <= '0;

            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        data_in_master <= req_mdata[int'(grant_idx)*DATA_W +: DATA_W];
                        data_in_slave  <= req_sdata[int'(grant_idx)*DATA_W +: DATA_W];
                        owner_grant    <= grant;
                        rr_ptr         <= grant_idx;
                        load_q         <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    start <= 1'b1;
                    count <= '0;
                    state <= ST_START;
                end

                ST_START: begin
                    state <= ST_WAIT;
                end

                // count runs 0..XFER_CYCLES-1 here, giving exactly
                // XFER_CYCLES WAIT cycles.
                ST_WAIT: begin
                    count <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        read_q <= 1'b1;
                        state  <= ST_READ;
                    end
                end

                ST_READ: begin
                    state <= ST_CAPT;
                end

                // The core updated data_out on the READ edge; sample it now
                // and pulse the owner in the following (IDLE) cycle.
                ST_CAPT: begin
                    rsp_mdata <= data_out_master;
                    rsp_sdata <= data_out_slave;
                    rsp_valid <= owner_grant;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_sequencer
//   Scoreboard bench. dut (XFER_CYCLES=16) is driven by per-requester queues;
//   expected responses are pushed when an accept is observed and popped when
//   rsp_valid fires. dut_1 (XFER_CYCLES=1) is driven directly for latency.
//   A small core model swaps the loaded words on each read pulse.
// ---------------------------------------------------------------------------
module tb_spi_xfer_sequencer;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int XC   = 16;
    localparam int XC1  = 1;

    typedef struct {
        logic [NREQ-1:0] owner;
        logic [DW-1:0]   m;
        logic [DW-1:0]   s;
        int              cyc;
    } exp_t;

    logic mclk;
    logic reset;

    // ---------------- dut (XFER_CYCLES = 16) ----------------
    logic [NREQ-1:0]    req_valid, req_ready, qv, glitch, rsp_valid;
    logic [NREQ*DW-1:0] req_mdata, req_sdata;
    logic [DW-1:0]      rsp_mdata, rsp_sdata;
    logic               busy, load_master, load_slave, start, read_master, read_slave;
    logic [DW-1:0]      data_in_master, data_in_slave, data_out_master, data_out_slave;
    logic [DW-1:0]      sh_m, sh_s;

    assign req_valid = qv | glitch;

    spi_xfer_sequencer #(.NREQ(NREQ), .DATA_W(DW), .XFER_CYCLES(XC)) dut (
        .mclk(mclk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mdata(req_mdata), .req_sdata(req_sdata),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_sdata(rsp_sdata),
        .busy(busy),
        .load_master(load_master), .load_slave(load_slave), .start(start),
        .read_master(read_master), .read_slave(read_slave),
        .data_in_master(data_in_master), .data_in_slave(data_in_slave),
        .data_out_master(data_out_master), .data_out_slave(data_out_slave)
    );

    // ---------------- dut_1 (XFER_CYCLES = 1) ----------------
    logic [NREQ-1:0]    req_valid_1, req_ready_1, rsp_valid_1;
    logic [NREQ*DW-1:0] req_mdata_1, req_sdata_1;
    logic [DW-1:0]      rsp_mdata_1, rsp_sdata_1;
    logic               busy_1, load_master_1, load_slave_1, start_1, read_master_1, read_slave_1;
    logic [DW-1:0]      data_in_master_1, data_in_slave_1, data_out_master_1, data_out_slave_1;
    logic [DW-1:0]      sh_m_1, sh_s_1;

    spi_xfer_sequencer #(.NREQ(NREQ), .DATA_W(DW), .XFER_CYCLES(XC1)) dut_1 (
        .mclk(mclk), .reset(reset),
        .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_mdata(req_mdata_1), .req_sdata(req_sdata_1),
        .rsp_valid(rsp_valid_1), .rsp_mdata(rsp_mdata_1), .rsp_sdata(rsp_sdata_1),
        .busy(busy_1),
        .load_master(load_master_1), .load_slave(load_slave_1), .start(start_1),
        .read_master(read_master_1), .read_slave(read_slave_1),
        .data_in_master(data_in_master_1), .data_in_slave(data_in_slave_1),
        .data_out_master(data_out_master_1), .data_out_slave(data_out_slave_1)
    );

    // ---------------- core models: read returns the other side's word ----------------
    initial begin
        data_out_master   = '0; data_out_slave   = '0; sh_m   = '0; sh_s   = '0;
        data_out_master_1 = '0; data_out_slave_1 = '0; sh_m_1 = '0; sh_s_1 = '0;
    end

    always @(posedge mclk) begin
        if (load_master)   sh_m   <= data_in_master;
        if (load_slave)    sh_s   <= data_in_slave;
        if (read_master)   data_out_master   <= sh_s;
        if (read_slave)    data_out_slave    <= sh_m;
        if (load_master_1) sh_m_1 <= data_in_master_1;
        if (load_slave_1)  sh_s_1 <= data_in_slave_1;
        if (read_master_1) data_out_master_1 <= sh_s_1;
        if (read_slave_1)  data_out_slave_1  <= sh_m_1;
    end

    // ---------------- clock, cycle count ----------------
    int cyc = 0;
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end
    initial forever begin
        @(posedge mclk);
        cyc++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard state ----------------
    exp_t        sb[$];
    logic [15:0] pend0[$];   // {mdata, sdata}
    logic [15:0] pend1[$];
    int          grant_log[$];
    int          acc_log[$];
    int cnt_load_m, cnt_load_s, cnt_start, cnt_read_m, cnt_read_s;

    task automatic clear_counts();
        cnt_load_m = 0; cnt_load_s = 0; cnt_start = 0; cnt_read_m = 0; cnt_read_s = 0;
        grant_log.delete();
        acc_log.delete();
    endtask

    // Requester driver: accept observed at negedge, queue advanced after the edge.
    initial begin
        logic [NREQ-1:0] acc;
        exp_t            e;
        qv = '0; req_mdata = '0; req_sdata = '0;
        forever begin
            @(negedge mclk);
            acc = reset ? (req_valid & req_ready) : '0;
            if (acc != '0) begin
                check("ready_onehot", $countones(acc), 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (acc[i]) begin
                        check("accept_has_request", 32'(qv[i]), 1);
                        e.owner = acc;
                        e.m     = req_sdata[i*DW +: DW];
                        e.s     = req_mdata[i*DW +: DW];
                        e.cyc   = cyc + XC + 5;
                        sb.push_back(e);
                        grant_log.push_back(i);
                        acc_log.push_back(cyc);
                    end
                end
            end
            @(posedge mclk);
            #1;
            if (acc[0] && qv[0]) void'(pend0.pop_front());
            if (acc[1] && qv[1]) void'(pend1.pop_front());
            qv[0] = (pend0.size() != 0);
            qv[1] = (pend1.size() != 0);
            req_mdata[7:0]  = qv[0] ? pend0[0][15:8] : 8'h00;
            req_sdata[7:0]  = qv[0] ? pend0[0][7:0]  : 8'h00;
            req_mdata[15:8] = qv[1] ? pend1[0][15:8] : 8'h00;
            req_sdata[15:8] = qv[1] ? pend1[0][7:0]  : 8'h00;
        end
    end

    // Response monitor and pulse counters.
    initial begin
        exp_t e;
        forever begin
            @(negedge mclk);
            if (reset) begin
                if (load_master) cnt_load_m++;
                if (load_slave)  cnt_load_s++;
                if (start)       cnt_start++;
                if (read_master) cnt_read_m++;
                if (read_slave)  cnt_read_s++;
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_owner", 32'(rsp_valid), 32'(e.owner));
                        check("rsp_mdata", 32'(rsp_mdata), 32'(e.m));
                        check("rsp_sdata", 32'(rsp_sdata), 32'(e.s));
                        check("rsp_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_start(input int max_cyc);
        bit seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge mclk);
            seen = start;
        end
        check("start_seen", 32'(seen), 1);
    endtask

    task automatic wait_drain(input int max_cyc);
        bit done = 1'b0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            @(negedge mclk);
            #2;
            done = (pend0.size() == 0) && (pend1.size() == 0) && (sb.size() == 0) && !busy;
        end
        check("drain_done", 32'(done), 1);
    endtask

    function automatic logic [31:0] ctrl_vec();
        return 32'({busy, load_master, load_slave, start, read_master, read_slave, rsp_valid, req_ready});
    endfunction

    function automatic logic [31:0] data_vec();
        return {data_in_master, data_in_slave, rsp_mdata, rsp_sdata};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int exp_order[4];
        int bad;
        logic [NREQ-1:0] ready_at_rsp;
        bit  rsp_seen;
        int  t_acc, t_start, t_read, t_rsp;
        logic [NREQ-1:0] got_v;
        logic [DW-1:0]   got_m, got_s;

        exp_order = '{0, 1, 0, 1};
        glitch = '0;
        req_valid_1 = '0; req_mdata_1 = '0; req_sdata_1 = '0;
        clear_counts();

        // Reset state.
        reset = 1'b0;
        repeat (3) @(negedge mclk);
        check("reset_ctrl", ctrl_vec(), 0);
        check("reset_data", data_vec(), 0);
        reset = 1'b1;
        @(negedge mclk);
        #1;
        check("idle_ctrl", ctrl_vec(), 0);

        // Both requesters held for four transactions: 0,1,0,1 back-to-back.
        clear_counts();
        pend0.push_back({8'h01, 8'h81}); pend0.push_back({8'h02, 8'h82});
        pend1.push_back({8'h11, 8'h91}); pend1.push_back({8'h12, 8'h92});
        wait_drain(200);
        check("rr_grant_count", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size() && k < 4; k++)
            check($sformatf("rr_grant_%0d", k), grant_log[k], exp_order[k]);
        for (int k = 1; k < acc_log.size(); k++)
            check($sformatf("b2b_spacing_%0d", k), acc_log[k] - acc_log[k-1], XC + 5);
        check("rr_start_pulses", cnt_start, 4);
        check("rr_load_pulses", cnt_load_m, 4);

        // Single transaction from requester 0.
        clear_counts();
        pend0.push_back({8'hA5, 8'h3C});
        wait_drain(100);
        check("t1_load_m", cnt_load_m, 1);
        check("t1_load_s", cnt_load_s, 1);
        check("t1_start", cnt_start, 1);
        check("t1_read_m", cnt_read_m, 1);
        check("t1_read_s", cnt_read_s, 1);
        check("t1_din_m_hold", 32'(data_in_master), 32'h A5);
        check("t1_din_s_hold", 32'(data_in_slave), 32'h3C);
        check("t1_rsp_m_hold", 32'(rsp_mdata), 32'h3C);

        // Requester 1 raised during WAIT: no ready until IDLE.
        clear_counts();
        pend0.push_back({8'h44, 8'h55});
        wait_start(10);
        repeat (3) @(negedge mclk);
        pend1.push_back({8'h66, 8'h77});
        bad = 0;
        rsp_seen = 1'b0;
        ready_at_rsp = '0;
        for (int n = 0; n < 40 && !rsp_seen; n++) begin
            @(negedge mclk);
            #2;
            if (rsp_valid != '0) begin
                rsp_seen = 1'b1;
                ready_at_rsp = req_ready;
            end else if (busy && req_ready != '0) begin
                bad++;
            end
        end
        check("t3_rsp_seen", 32'(rsp_seen), 1);
        check("t3_ready_while_busy", bad, 0);
        check("t3_ready_at_idle", 32'(ready_at_rsp), 32'b10);

        // Requester 0 pulsed for one cycle while busy with requester 1's transaction.
        @(negedge mclk);
        @(posedge mclk); #1 glitch = 2'b01;
        @(posedge mclk); #1 glitch = 2'b00;
        wait_drain(100);
        repeat (30) @(negedge mclk);
        check("t6_single_txn", cnt_start, 2);
        check("t6_grants", grant_log.size(), 2);

        // Reset during WAIT abandons the transaction.
        clear_counts();
        pend0.push_back({8'hDE, 8'hAD});
        wait_start(10);
        repeat (4) @(negedge mclk);
        reset = 1'b0;
        #1;
        check("t4_reset_ctrl", ctrl_vec(), 0);
        check("t4_reset_data", data_vec(), 0);
        sb.delete();
        repeat (3) @(negedge mclk);
        reset = 1'b1;
        check("t4_no_read", cnt_read_m, 0);
        clear_counts();
        pend0.push_back({8'hC0, 8'h0C});
        pend1.push_back({8'hF0, 8'h0F});
        wait_drain(200);
        check("t4_grant_count", grant_log.size(), 2);
        if (grant_log.size() > 0) check("t4_first_grant", grant_log[0], 0);

        // XFER_CYCLES = 1 latency on dut_1.
        @(negedge mclk);
        req_mdata_1 = {8'h00, 8'h5A};
        req_sdata_1 = {8'h00, 8'hC3};
        req_valid_1 = 2'b01;
        t_acc = -1;
        for (int n = 0; n < 10 && t_acc < 0; n++) begin
            @(negedge mclk);
            if ((req_valid_1 & req_ready_1) != '0) t_acc = cyc;
        end
        @(posedge mclk);
        #1 req_valid_1 = '0;
        t_start = -1; t_read = -1; t_rsp = -1;
        got_v = '0; got_m = '0; got_s = '0;
        for (int n = 0; n < 30 && t_rsp < 0; n++) begin
            @(negedge mclk);
            if (start_1 && t_start < 0) t_start = cyc;
            if (read_master_1 && t_read < 0) t_read = cyc;
            if (rsp_valid_1 != '0) begin
                t_rsp = cyc;
                got_v = rsp_valid_1;
                got_m = rsp_mdata_1;
                got_s = rsp_sdata_1;
            end
        end
        check("t5_accepted", 32'(t_acc >= 0), 1);
        check("t5_latency", t_rsp - t_acc, XC1 + 5);
        check("t5_start_to_read", t_read - t_start, 2);
        check("t5_rsp_valid", 32'(got_v), 32'b01);
        check("t5_rsp_mdata", 32'(got_m), 32'hC3);
        check("t5_rsp_sdata", 32'(got_s), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
